// File: rtl/tf_rom_wr_ctrl_pkg.sv
// Shared definitions for the twiddle-ROM write controller: lane and word
// widths, address and ROM-count defaults, write-code bit positions and the
// pass-framing state encoding.
package tf_rom_wr_ctrl_pkg;

   localparam int P_WIDTH  = 64;
   localparam int SD_WIDTH = 2 * P_WIDTH;
   localparam int ADDR_W   = 4;
   localparam int NROM     = 8;
   localparam int SEL_W    = $clog2(NROM);

   localparam int W_LO = 0;
   localparam int W_HI = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/tf_rom_wr_ctrl_if.sv
// Bundle between the horizontal twiddle stage (master) and the ROM write
// controller (slave): pass framing, the three data lanes, per-ROM write
// codes and the shared twiddle-RAM write port with status flags.
interface tf_rom_wr_ctrl_if;
   import tf_rom_wr_ctrl_pkg::*;

   logic                start;
   logic                last_in;
   logic [P_WIDTH-1:0]  rom0_data;
   logic [P_WIDTH-1:0]  lo_data;
   logic [P_WIDTH-1:0]  hi_data;
   logic                rom0_w;
   logic [1:0]          rom1_w;
   logic [1:0]          rom2_w;
   logic [1:0]          rom3_w;
   logic [1:0]          rom4_w;
   logic [1:0]          rom5_w;
   logic [1:0]          rom6_w;
   logic [1:0]          rom7_w;

   logic                wr_en;
   logic [SEL_W-1:0]    wr_sel;
   logic [ADDR_W-1:0]   wr_addr;
   logic [SD_WIDTH-1:0] wr_data;
   logic                busy;
   logic                done;
   logic                ovf_err;

   modport master (
      output start, last_in, rom0_data, lo_data, hi_data, rom0_w,
             rom1_w, rom2_w, rom3_w, rom4_w, rom5_w, rom6_w, rom7_w,
      input  wr_en, wr_sel, wr_addr, wr_data, busy, done, ovf_err
   );

   modport slave (
      input  start, last_in, rom0_data, lo_data, hi_data, rom0_w,
             rom1_w, rom2_w, rom3_w, rom4_w, rom5_w, rom6_w, rom7_w,
      output wr_en, wr_sel, wr_addr, wr_data, busy, done, ovf_err
   );

endinterface

// File: rtl/tf_half_stager.sv
// Staging for one 128-bit ROM: collects the low and high 64-bit halves in
// any order, raises pending once both are present, and flags halves that
// arrive while the slot is still occupied. A grant in the same cycle frees
// the slot so a new half can land in freshly cleared staging.
module tf_half_stager
   import tf_rom_wr_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                cap_en,
   input  logic [1:0]          w_code,
   input  logic [P_WIDTH-1:0]  lo_data,
   input  logic [P_WIDTH-1:0]  hi_data,
   input  logic                grant,
   output logic                pending,
   output logic [SD_WIDTH-1:0] staging,
   output logic                drop
);

   logic lo_valid, hi_valid;
   logic lo_in, hi_in;
   logic lo_drop, hi_drop;
   logic lo_acc, hi_acc;
   logic lo_valid_nxt, hi_valid_nxt;

   // Decide which arriving halves are accepted and which overflow
   always_comb begin
      lo_in        = cap_en & w_code[W_LO];
      hi_in        = cap_en & w_code[W_HI];
      lo_drop      = lo_in & ~grant & (pending | lo_valid);
      hi_drop      = hi_in & ~grant & (pending | hi_valid);
      lo_acc       = lo_in & ~lo_drop;
      hi_acc       = hi_in & ~hi_drop;
      drop         = lo_drop | hi_drop;
      lo_valid_nxt = (lo_valid & ~grant) | lo_acc;
      hi_valid_nxt = (hi_valid & ~grant) | hi_acc;
   end

   // Staging word, half-valid flags and pending bit
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         staging  <= '0;
         lo_valid <= 1'b0;
         hi_valid <= 1'b0;
         pending  <= 1'b0;
      end else if (clear) begin
         staging  <= '0;
         lo_valid <= 1'b0;
         hi_valid <= 1'b0;
         pending  <= 1'b0;
      end else begin
         if (grant) begin
            staging <= '0;
         end
         if (lo_acc) begin
            staging[P_WIDTH-1:0] <= lo_data;
         end
         if (hi_acc) begin
            staging[SD_WIDTH-1:P_WIDTH] <= hi_data;
         end
         lo_valid <= lo_valid_nxt;
         hi_valid <= hi_valid_nxt;
         pending  <= lo_valid_nxt & hi_valid_nxt;
      end
   end

endmodule

// File: rtl/tf_rom_wr_ctrl.sv
// Twiddle-ROM write controller: frames an update pass, stages ROM0 words and
// assembles ROM1..7 words from 64-bit halves, then arbitrates completed words
// onto the single shared twiddle-RAM write port with per-ROM addresses.
module tf_rom_wr_ctrl
   import tf_rom_wr_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   tf_rom_wr_ctrl_if.slave bus
);

   state_t              state;
   logic                clear;
   logic                cap_en;
   logic [1:0]          w_code     [1:NROM-1];
   logic [NROM-1:0]     pend;
   logic [NROM-1:0]     drop_vec;
   logic [NROM-1:0]     grant;
   logic [SD_WIDTH-1:0] stage_word [NROM];
   logic [P_WIDTH-1:0]  rom0_stage;
   logic                rom0_pend;
   logic                rom0_in;
   logic                rom0_drop;
   logic [ADDR_W-1:0]   addr       [NROM];
   logic [SEL_W-1:0]    grant_idx;
   logic                grant_any;

   assign clear  = (state == IDLE) && bus.start;
   assign cap_en = (state == COLLECT);

   assign w_code[1] = bus.rom1_w;
   assign w_code[2] = bus.rom2_w;
   assign w_code[3] = bus.rom3_w;
   assign w_code[4] = bus.rom4_w;
   assign w_code[5] = bus.rom5_w;
   assign w_code[6] = bus.rom6_w;
   assign w_code[7] = bus.rom7_w;

   assign rom0_in       = cap_en & bus.rom0_w;
   assign rom0_drop     = rom0_in & rom0_pend & ~grant[0];
   assign pend[0]       = rom0_pend;
   assign drop_vec[0]   = rom0_drop;
   assign stage_word[0] = {{(SD_WIDTH-P_WIDTH){1'b0}}, rom0_stage};

   for (genvar k = 1; k < NROM; k++) begin : g_stager
      tf_half_stager u_stager (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear   (clear),
         .cap_en  (cap_en),
         .w_code  (w_code[k]),
         .lo_data (bus.lo_data),
         .hi_data (bus.hi_data),
         .grant   (grant[k]),
         .pending (pend[k]),
         .staging (stage_word[k]),
         .drop    (drop_vec[k])
      );
   end

   // Fixed-priority arbiter: the lowest-numbered pending ROM wins
   always_comb begin
      grant_idx = '0;
      grant     = '0;
      grant_any = |pend;
      for (int i = NROM - 1; i >= 0; i--) begin
         if (pend[i]) begin
            grant_idx = SEL_W'(i);
         end
      end
      for (int i = 0; i < NROM; i++) begin
         grant[i] = grant_any && (grant_idx == SEL_W'(i));
      end
   end

   // ROM0 words need no assembly; a single request stages the whole word
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rom0_stage <= '0;
         rom0_pend  <= 1'b0;
      end else if (clear) begin
         rom0_stage <= '0;
         rom0_pend  <= 1'b0;
      end else begin
         if (grant[0]) begin
            rom0_stage <= '0;
            rom0_pend  <= 1'b0;
         end
         if (rom0_in && !rom0_drop) begin
            rom0_stage <= bus.rom0_data;
            rom0_pend  <= 1'b1;
         end
      end
   end

   // Per-ROM address counters advance on each granted write and wrap naturally
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < NROM; i++) begin
            addr[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < NROM; i++) begin
            addr[i] <= '0;
         end
      end else if (grant_any) begin
         addr[grant_idx] <= addr[grant_idx] + 1'b1;
      end
   end

   // Register the granted word onto the shared write port; hold it when idle
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         bus.wr_en   <= 1'b0;
         bus.wr_sel  <= '0;
         bus.wr_addr <= '0;
         bus.wr_data <= '0;
      end else begin
         bus.wr_en <= grant_any;
         if (grant_any) begin
            bus.wr_sel  <= grant_idx;
            bus.wr_addr <= addr[grant_idx];
            bus.wr_data <= stage_word[grant_idx];
         end
      end
   end

   // Sticky overflow flag, cleared only when a new pass begins
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         bus.ovf_err <= 1'b0;
      end else if (clear) begin
         bus.ovf_err <= 1'b0;
      end else if (|drop_vec) begin
         bus.ovf_err <= 1'b1;
      end
   end

   // Pass framing FSM with registered busy and done outputs
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state    <= IDLE;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  state    <= COLLECT;
                  bus.busy <= 1'b1;
               end
            end
            COLLECT: begin
               if (bus.last_in) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if ((pend == '0) && !bus.wr_en) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tf_rom_wr_ctrl.sv
// Directed self-checking bench for tf_rom_wr_ctrl. A negedge monitor logs
// every write on the shared port; each scenario task drives its stimulus and
// compares the log and status flags against hand-computed values.
module tb_tf_rom_wr_ctrl;
   import tf_rom_wr_ctrl_pkg::*;

   typedef struct {
      logic [2:0]   sel;
      logic [3:0]   addr;
      logic [127:0] data;
      int           cyc;
   } wr_rec_t;

   logic      clk = 1'b0;
   logic      rst_n;
   int        checks = 0;
   int        errors = 0;
   int        cyc = 0;
   wr_rec_t   wlog[$];

   tf_rom_wr_ctrl_if bus ();

   tf_rom_wr_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   // Edge counter used to time writes relative to captures
   always @(posedge clk) cyc <= cyc + 1;

   // Log every write strobe away from the active edge
   always @(negedge clk) begin
      wr_rec_t r;
      if (!rst_n && bus.wr_en === 1'b1) begin
         r.sel  = bus.wr_sel;
         r.addr = bus.wr_addr;
         r.data = bus.wr_data;
         r.cyc  = cyc;
         wlog.push_back(r);
      end
   end

   // Hard time limit so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      bus.start     = 1'b0;
      bus.last_in   = 1'b0;
      bus.rom0_data = '0;
      bus.lo_data   = '0;
      bus.hi_data   = '0;
      bus.rom0_w    = 1'b0;
      bus.rom1_w    = 2'b00;
      bus.rom2_w    = 2'b00;
      bus.rom3_w    = 2'b00;
      bus.rom4_w    = 2'b00;
      bus.rom5_w    = 2'b00;
      bus.rom6_w    = 2'b00;
      bus.rom7_w    = 2'b00;
   endtask

   task automatic do_start;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_pass(output int pulses);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.done === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      clear_inputs();
      repeat (3) tick();
      checks++;
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got wr_en=%b busy=%b done=%b ovf=%b expected all 0",
                  bus.wr_en, bus.busy, bus.done, bus.ovf_err);
      end
      checks++;
      if (bus.wr_sel !== 3'd0 || bus.wr_addr !== 4'd0 || bus.wr_data !== 128'd0) begin
         errors++;
         $display("[TB] FAIL reset_port: got sel=%0d addr=%0d data=%h expected 0", bus.wr_sel, bus.wr_addr, bus.wr_data);
      end
      rst_n = 1'b0;
      tick();
      wlog.delete();
      bus.rom3_w  = 2'b11;
      bus.lo_data = 64'h1;
      bus.hi_data = 64'h2;
      repeat (2) tick();
      clear_inputs();
      repeat (3) tick();
      checks++;
      if (wlog.size() != 0 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_ignore: got writes=%0d busy=%b expected 0 and 0", wlog.size(), bus.busy);
      end
   endtask

   task automatic test_single_word;
      int p;
      wlog.delete();
      do_start();
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_busy: got %b expected 1", bus.busy);
      end
      bus.rom3_w  = 2'b11;
      bus.lo_data = 64'h1111;
      bus.hi_data = 64'h2222;
      bus.last_in = 1'b1;
      tick();
      clear_inputs();
      run_pass(p);
      checks++;
      if (p != 1) begin
         errors++;
         $display("[TB] FAIL single_done: got %0d pulses expected 1", p);
      end
      checks++;
      if (wlog.size() != 1) begin
         errors++;
         $display("[TB] FAIL single_count: got %0d writes expected 1", wlog.size());
      end else begin
         checks++;
         if (wlog[0].sel !== 3'd3 || wlog[0].addr !== 4'd0 || wlog[0].data !== {64'h2222, 64'h1111}) begin
            errors++;
            $display("[TB] FAIL single_write: got sel=%0d addr=%0d data=%h expected sel=3 addr=0 data=%h",
                     wlog[0].sel, wlog[0].addr, wlog[0].data, {64'h2222, 64'h1111});
         end
      end
      checks++;
      if (bus.ovf_err !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_flags: got ovf=%b busy=%b expected 0 0", bus.ovf_err, bus.busy);
      end
   endtask

   task automatic test_split_halves;
      int p;
      int e;
      wlog.delete();
      do_start();
      bus.rom5_w  = 2'b10;
      bus.hi_data = 64'hAA;
      tick();
      clear_inputs();
      repeat (2) tick();
      checks++;
      if (wlog.size() != 0) begin
         errors++;
         $display("[TB] FAIL split_early: got %0d writes expected 0", wlog.size());
      end
      bus.rom5_w  = 2'b01;
      bus.lo_data = 64'hBB;
      tick();
      e = cyc;
      clear_inputs();
      bus.last_in = 1'b1;
      tick();
      clear_inputs();
      run_pass(p);
      checks++;
      if (wlog.size() != 1) begin
         errors++;
         $display("[TB] FAIL split_count: got %0d writes expected 1", wlog.size());
      end else begin
         checks++;
         if (wlog[0].sel !== 3'd5 || wlog[0].data !== {64'hAA, 64'hBB}) begin
            errors++;
            $display("[TB] FAIL split_write: got sel=%0d data=%h expected sel=5 data=%h",
                     wlog[0].sel, wlog[0].data, {64'hAA, 64'hBB});
         end
         checks++;
         if (wlog[0].cyc != e + 1) begin
            errors++;
            $display("[TB] FAIL split_latency: got write at %0d expected %0d", wlog[0].cyc, e + 1);
         end
      end
   endtask

   task automatic test_simultaneous;
      int p;
      int e;
      wlog.delete();
      do_start();
      bus.rom0_w    = 1'b1;
      bus.rom0_data = 64'hC0C0;
      bus.rom1_w    = 2'b11;
      bus.rom7_w    = 2'b11;
      bus.lo_data   = 64'h1357;
      bus.hi_data   = 64'h2468;
      bus.last_in   = 1'b1;
      tick();
      e = cyc;
      clear_inputs();
      run_pass(p);
      checks++;
      if (wlog.size() != 3) begin
         errors++;
         $display("[TB] FAIL simul_count: got %0d writes expected 3", wlog.size());
      end else begin
         checks++;
         if (wlog[0].sel !== 3'd0 || wlog[1].sel !== 3'd1 || wlog[2].sel !== 3'd7) begin
            errors++;
            $display("[TB] FAIL simul_order: got %0d,%0d,%0d expected 0,1,7", wlog[0].sel, wlog[1].sel, wlog[2].sel);
         end
         checks++;
         if (wlog[0].cyc != e + 1 || wlog[1].cyc != e + 2 || wlog[2].cyc != e + 3) begin
            errors++;
            $display("[TB] FAIL simul_timing: got %0d,%0d,%0d expected %0d,%0d,%0d",
                     wlog[0].cyc, wlog[1].cyc, wlog[2].cyc, e + 1, e + 2, e + 3);
         end
         checks++;
         if (wlog[0].data[127:64] !== 64'd0 || wlog[0].data !== {64'h0, 64'hC0C0}) begin
            errors++;
            $display("[TB] FAIL simul_rom0: got %h expected %h", wlog[0].data, {64'h0, 64'hC0C0});
         end
         checks++;
         if (wlog[1].data !== {64'h2468, 64'h1357} || wlog[2].data !== {64'h2468, 64'h1357}) begin
            errors++;
            $display("[TB] FAIL simul_data: got %h / %h expected %h", wlog[1].data, wlog[2].data, {64'h2468, 64'h1357});
         end
      end
   endtask

   task automatic test_addr_wrap;
      int p;
      logic [3:0]   ea;
      logic [127:0] ed;
      wlog.delete();
      do_start();
      for (int i = 0; i < 17; i++) begin
         bus.rom2_w  = 2'b11;
         bus.lo_data = 64'(i);
         bus.hi_data = 64'(i + 256);
         bus.last_in = (i == 16);
         tick();
      end
      clear_inputs();
      run_pass(p);
      checks++;
      if (wlog.size() != 17 || p != 1) begin
         errors++;
         $display("[TB] FAIL wrap_count: got %0d writes %0d done expected 17 and 1", wlog.size(), p);
      end else begin
         for (int j = 0; j < 17; j++) begin
            ea = 4'(j % 16);
            ed = {64'(j + 256), 64'(j)};
            checks++;
            if (wlog[j].sel !== 3'd2 || wlog[j].addr !== ea || wlog[j].data !== ed) begin
               errors++;
               $display("[TB] FAIL wrap_write%0d: got sel=%0d addr=%0d data=%h expected sel=2 addr=%0d data=%h",
                        j, wlog[j].sel, wlog[j].addr, wlog[j].data, ea, ed);
            end
         end
      end
      checks++;
      if (bus.ovf_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_ovf: got %b expected 0", bus.ovf_err);
      end
   endtask

   task automatic test_overflow;
      int p;
      wlog.delete();
      do_start();
      bus.rom4_w  = 2'b01;
      bus.lo_data = 64'h44;
      tick();
      bus.lo_data = 64'h55;
      tick();
      clear_inputs();
      checks++;
      if (bus.ovf_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_set: got %b expected 1", bus.ovf_err);
      end
      bus.rom4_w  = 2'b10;
      bus.hi_data = 64'h66;
      bus.last_in = 1'b1;
      tick();
      clear_inputs();
      run_pass(p);
      checks++;
      if (wlog.size() != 1) begin
         errors++;
         $display("[TB] FAIL ovf_count: got %0d writes expected 1", wlog.size());
      end else begin
         checks++;
         if (wlog[0].sel !== 3'd4 || wlog[0].data !== {64'h66, 64'h44}) begin
            errors++;
            $display("[TB] FAIL ovf_data: got sel=%0d data=%h expected sel=4 data=%h",
                     wlog[0].sel, wlog[0].data, {64'h66, 64'h44});
         end
      end
      checks++;
      if (bus.ovf_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_sticky: got %b expected 1", bus.ovf_err);
      end
      wlog.delete();
      do_start();
      checks++;
      if (bus.ovf_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_clear: got %b expected 0", bus.ovf_err);
      end
      bus.last_in = 1'b1;
      tick();
      clear_inputs();
      run_pass(p);
      checks++;
      if (wlog.size() != 0 || p != 1) begin
         errors++;
         $display("[TB] FAIL empty_pass: got %0d writes %0d done expected 0 and 1", wlog.size(), p);
      end
   endtask

   task automatic test_reset_mid_pass;
      int p;
      wlog.delete();
      do_start();
      bus.rom6_w  = 2'b10;
      bus.hi_data = 64'h6666;
      tick();
      clear_inputs();
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_flags: got wr_en=%b busy=%b done=%b ovf=%b expected all 0",
                  bus.wr_en, bus.busy, bus.done, bus.ovf_err);
      end
      checks++;
      if (bus.wr_sel !== 3'd0 || bus.wr_addr !== 4'd0 || bus.wr_data !== 128'd0) begin
         errors++;
         $display("[TB] FAIL midrst_port: got sel=%0d addr=%0d data=%h expected 0", bus.wr_sel, bus.wr_addr, bus.wr_data);
      end
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      do_start();
      bus.rom6_w  = 2'b01;
      bus.lo_data = 64'h77;
      tick();
      clear_inputs();
      bus.last_in = 1'b1;
      tick();
      clear_inputs();
      run_pass(p);
      checks++;
      if (wlog.size() != 0 || p != 1) begin
         errors++;
         $display("[TB] FAIL midrst_nowrite: got %0d writes %0d done expected 0 and 1", wlog.size(), p);
      end
   endtask

   // Scenario sequence and summary
   initial begin
      test_reset();
      test_single_word();
      test_split_halves();
      test_simultaneous();
      test_addr_wrap();
      test_overflow();
      test_reset_mid_pass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tf_rom_wr_ctrl.md
Name: tf_rom_wr_ctrl

Overview:
- Sits directly downstream of the horizontal twiddle-generation stage.
- Consumes its processed twiddle outputs (three 64-bit lanes) and per-ROM write codes (ROM0 1-bit, ROM1..ROM7 2-bit).
- Assembles 128-bit words from 64-bit halves and arbitrates them onto one shared twiddle-RAM write port, with per-ROM address counters.
- A small FSM frames one update pass: start, collect, drain, done.

Parameters:
- P_WIDTH, 64, lane width.
- SD_WIDTH, 128, ROM1..ROM7 word width (= 2*P_WIDTH).
- ADDR_W, 4, per-ROM address width; counters wrap at 2^ADDR_W.
- NROM, 8, number of ROMs (ROM0..ROM7).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse: begin an update pass.
- last_in  in  1  one-cycle pulse: final input beat of the pass.
- rom0_data  in  P_WIDTH  lane 0; the ROM0 word.
- lo_data  in  P_WIDTH  lane 1; ROM1..7 low half.
- hi_data  in  P_WIDTH  lane 2; ROM1..7 high half.
- rom0_w  in  1  ROM0 write request.
- romk_w (k=1..7)  in  2  bit0 = capture low half, bit1 = capture high half.
- wr_en  out  1  shared write strobe.
- wr_sel  out  3  target ROM index.
- wr_addr  out  ADDR_W  target address.
- wr_data  out  SD_WIDTH  write word; ROM0 words are zero-extended.
- busy  out  1  high in COLLECT or DRAIN.
- done  out  1  one-cycle pulse at end of pass.
- ovf_err  out  1  sticky overflow flag.

Behaviour:
- Reset: wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, busy=0, done=0, ovf_err=0. All staging, pending bits and address counters = 0; FSM = IDLE.
- FSM IDLE:
  - start -> COLLECT.
  - On entry to COLLECT: clear all address counters, staging, pending and ovf_err.
  - Write codes are ignored in IDLE.
- FSM COLLECT:
  - Captures input halves.
  - last_in -> DRAIN. The last_in beat's captures are still taken.
- FSM DRAIN:
  - No new captures.
  - When no pending bits remain and no write is issuing -> DONE.
- FSM DONE: done=1 for exactly one cycle, then -> IDLE.
- start while busy: ignored.
- Capture, ROM0: rom0_w=1 loads the staging word with {0, rom0_data} and sets pending[0] at the next edge.
- Capture, ROMk (k=1..7):
  - bit0 latches lo_data into staging[k][63:0] and sets lo_valid[k].
  - bit1 latches hi_data into staging[k][127:64] and sets hi_valid[k].
  - Code 2'b11 captures both halves in one cycle.
  - When lo_valid and hi_valid are both set, pending[k] is set. The halves may arrive in either order, in different cycles.
- Overflow:
  - A half arriving for a ROM whose pending bit is set, or whose same half is already valid, is dropped.
  - ovf_err is set and stays set until the next start.
  - Exception: if pending[k] is granted in the same cycle, the new half is accepted into freshly cleared staging.
- Arbitration:
  - One grant per cycle, fixed priority, lowest index first.
  - The grant registers wr_en=1, wr_sel=k, wr_addr=addr[k], wr_data=staging[k] for exactly one cycle.
  - On grant: pending[k], lo_valid[k] and hi_valid[k] clear, and addr[k] increments, wrapping 2^ADDR_W-1 -> 0.
- Latency: the last half captured at edge N sets pending at edge N. With no competing pending bit, wr_en is high in the cycle after edge N+1 (1 cycle of arbitration).
- wr_en=0: wr_sel, wr_addr and wr_data hold their previous values.
- Reset mid-pass: everything returns to reset values immediately. Partial staging is discarded; no write is issued.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, COLLECT=2'd1, DRAIN=2'd2, DONE=2'd3.
  - Write-code bit positions: W_LO=0, W_HI=1.
  - NROM and ADDR_W defaults.
- Natural sub-module: tf_half_stager.
  - One instance per ROM1..7.
  - Contains the staging register, lo/hi valid bits, pending bit and overflow detect.
  - Top level holds the FSM, priority arbiter, address counters and ROM0 path.

Test Plan:
- Single full word:
  - Stimulus: start, then ROM3_w=2'b11 with lo=0x1111, hi=0x2222, then last_in.
  - Required: one write with wr_sel=3, wr_addr=0, wr_data={0x2222,0x1111}; done pulses once; ovf_err=0.
- Split halves, reverse order:
  - Stimulus: ROM5_w=2'b10 with hi=0xAA, then two idle cycles, then ROM5_w=2'b01 with lo=0xBB.
  - Required: exactly one write, wr_sel=5, wr_data={0xAA,0xBB}, issued 1 cycle after the second capture.
- Simultaneous completion:
  - Stimulus: rom0_w=1 and ROM1_w=ROM7_w=2'b11 in the same cycle.
  - Required: three writes on consecutive cycles with wr_sel order 0, 1, 7; ROM0 wr_data upper 64 bits = 0.
- Address wrap:
  - Stimulus: 17 complete ROM2 words in one pass (ADDR_W=4).
  - Required: wr_addr sequence 0..15 then 0.
- Overflow:
  - Stimulus: ROM4_w=2'b01 twice, with no hi half in between.
  - Required: ovf_err=1, second lo half dropped; ovf_err persists until the next start, where it clears.
- Reset mid-pass:
  - Stimulus: ROM6 hi half captured, then rst_n asserted.
  - Required: all outputs return to reset values, busy=0, and no write occurs after release.
